// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit multicycle processor control path:
// FSM states, opcode patterns, ALU operand/operation codes and control bundles.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LD1    = 4'd3,
        ST_LD2    = 4'd4,
        ST_ST     = 4'd5,
        ST_EXEC   = 4'd6,
        ST_WB     = 4'd7,
        ST_BR     = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    // '?' digits are wildcards when these are used as casez items
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_ORI   = 4'b?111;
    localparam logic [3:0] OP_SHIFT = 4'b?011;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_NOP   = 4'b1010;

    localparam logic [2:0] ALU2_R2    = 3'b000;
    localparam logic [2:0] ALU2_ONE   = 3'b001;
    localparam logic [2:0] ALU2_SE4   = 3'b010;
    localparam logic [2:0] ALU2_ZE5   = 3'b011;
    localparam logic [2:0] ALU2_ZE3   = 3'b100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_NAND  = 3'b011;
    localparam logic [2:0] ALUOP_SHIFT = 3'b100;

    localparam logic ADDR_PC   = 1'b1;
    localparam logic ADDR_R2   = 1'b0;
    localparam logic REGIN_ALU = 1'b1;
    localparam logic REGIN_MDR = 1'b0;
    localparam logic ALU1_PC   = 1'b0;
    localparam logic ALU1_R1   = 1'b1;

    typedef struct packed {
        logic load;
        logic store;
        logic add;
        logic sub;
        logic nand_op;
        logic ori;
        logic shift;
        logic bz;
        logic bnz;
        logic bpz;
        logic stop;
        logic nop;
    } iclass_t;

    typedef struct packed {
        logic       pc_write;
        logic       addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       ir_load;
        logic       mdr_load;
        logic       r1r2_load;
        logic       ext_load;
        logic       alu1;
        logic [2:0] alu2;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       flag_write;
        logic       reg_in;
        logic       rf_write;
        logic       halt;
    } ctrl_t;

    // Control word presented while in state st; the branch-taken PC load and
    // R1Sel depend on live inputs and are added by the controller itself.
    function automatic ctrl_t ctrl_for_state(input state_t st, input iclass_t cls);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.addr_sel = ADDR_PC;
                c.mem_read = 1'b1;
                c.ir_load  = 1'b1;
                c.alu1     = ALU1_PC;
                c.alu2     = ALU2_ONE;
                c.alu_op   = ALUOP_ADD;
                c.pc_write = 1'b1;
            end
            ST_DECODE: begin
                c.r1r2_load = 1'b1;
                c.ext_load  = 1'b1;
            end
            ST_LD1: begin
                c.addr_sel = ADDR_R2;
                c.mem_read = 1'b1;
                c.mdr_load = 1'b1;
            end
            ST_LD2: begin
                c.reg_in   = REGIN_MDR;
                c.rf_write = 1'b1;
            end
            ST_ST: begin
                c.addr_sel  = ADDR_R2;
                c.mem_write = 1'b1;
            end
            ST_EXEC: begin
                c.alu1          = ALU1_R1;
                c.alu_out_write = 1'b1;
                c.flag_write    = 1'b1;
                if (cls.sub) begin
                    c.alu2   = ALU2_R2;
                    c.alu_op = ALUOP_SUB;
                end else if (cls.nand_op) begin
                    c.alu2   = ALU2_R2;
                    c.alu_op = ALUOP_NAND;
                end else if (cls.ori) begin
                    c.alu2   = ALU2_ZE5;
                    c.alu_op = ALUOP_OR;
                end else if (cls.shift) begin
                    c.alu2   = ALU2_ZE3;
                    c.alu_op = ALUOP_SHIFT;
                end else begin
                    c.alu2   = ALU2_R2;
                    c.alu_op = ALUOP_ADD;
                end
            end
            ST_WB: begin
                c.reg_in   = REGIN_ALU;
                c.rf_write = 1'b1;
            end
            ST_BR: begin
                c.alu1   = ALU1_PC;
                c.alu2   = ALU2_SE4;
                c.alu_op = ALUOP_ADD;
            end
            ST_HALT: begin
                c.halt = 1'b1;
            end
            ST_RESET: begin
                c = '0;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    function automatic logic branch_taken(input iclass_t cls, input logic n, input logic z);
        return (cls.bz & z) | (cls.bnz & ~z) | (cls.bpz & ~n);
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Opcode classifier: maps IR[3:0] to a one-hot instruction class.
// The x111 (ORI) and x011 (SHIFT) wildcard patterns take priority.
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [3:0] instr,
    output iclass_t    cls
);

    // one-hot class lookup; unlisted codes behave as NOP
    always_comb begin
        cls = '0;
        casez (instr)
            OP_ORI:   cls.ori     = 1'b1;
            OP_SHIFT: cls.shift   = 1'b1;
            OP_LOAD:  cls.load    = 1'b1;
            OP_STORE: cls.store   = 1'b1;
            OP_ADD:   cls.add     = 1'b1;
            OP_SUB:   cls.sub     = 1'b1;
            OP_NAND:  cls.nand_op = 1'b1;
            OP_BZ:    cls.bz      = 1'b1;
            OP_BNZ:   cls.bnz     = 1'b1;
            OP_BPZ:   cls.bpz     = 1'b1;
            OP_STOP:  cls.stop    = 1'b1;
            OP_NOP:   cls.nop     = 1'b1;
            default:  cls.nop     = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/writeback and drives
// every datapath enable and select of the 8-bit processor.
module multicycle_ctrl
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Instr,
    input  logic       N,
    input  logic       Z,
    output logic       PCwrite,
    output logic       AddrSel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRload,
    output logic       MDRload,
    output logic       R1Sel,
    output logic       R1R2Load,
    output logic       ExtLoad,
    output logic       ALU1,
    output logic [2:0] ALU2,
    output logic [2:0] ALUop,
    output logic       ALUOutWrite,
    output logic       FlagWrite,
    output logic       RegIn,
    output logic       RFWrite,
    output logic       Halt
);

    iclass_t cls_s;
    state_t  state_r;
    state_t  state_nx_s;
    ctrl_t   ctrl_r;
    ctrl_t   ctrl_nx_s;
    logic    decode_r;
    logic    br_r;
    logic    taken_s;

    instr_class_decode u_class (
        .instr (Instr),
        .cls   (cls_s)
    );

    // next-state selection
    always_comb begin
        state_nx_s = ST_RESET;
        case (state_r)
            ST_RESET:  state_nx_s = ST_FETCH;
            ST_FETCH:  state_nx_s = ST_DECODE;
            ST_DECODE: begin
                if (cls_s.load) begin
                    state_nx_s = ST_LD1;
                end else if (cls_s.store) begin
                    state_nx_s = ST_ST;
                end else if (cls_s.add | cls_s.sub | cls_s.nand_op | cls_s.ori | cls_s.shift) begin
                    state_nx_s = ST_EXEC;
                end else if (cls_s.bz | cls_s.bnz | cls_s.bpz) begin
                    state_nx_s = ST_BR;
                end else if (cls_s.stop) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_LD1:    state_nx_s = ST_LD2;
            ST_LD2:    state_nx_s = ST_FETCH;
            ST_ST:     state_nx_s = ST_FETCH;
            ST_EXEC:   state_nx_s = ST_WB;
            ST_WB:     state_nx_s = ST_FETCH;
            ST_BR:     state_nx_s = ST_FETCH;
            ST_HALT:   state_nx_s = ST_HALT;
            default:   state_nx_s = ST_RESET;
        endcase
    end

    // control word for the state being entered; Instr is already valid when leaving DECODE
    always_comb begin
        ctrl_nx_s = ctrl_for_state(state_nx_s, cls_s);
    end

    // state register and registered control outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RESET;
            ctrl_r   <= '0;
            decode_r <= 1'b0;
            br_r     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            ctrl_r   <= ctrl_nx_s;
            decode_r <= (state_nx_s == ST_DECODE);
            br_r     <= (state_nx_s == ST_BR);
        end
    end

    // IR and the flags only settle once DECODE/BR are entered, so those terms stay live
    always_comb begin
        taken_s = branch_taken(cls_s, N, Z);
    end

    assign PCwrite     = ctrl_r.pc_write | (br_r & taken_s);
    assign R1Sel       = decode_r & (Instr[2:0] == 3'b111);
    assign AddrSel     = ctrl_r.addr_sel;
    assign MemRead     = ctrl_r.mem_read;
    assign MemWrite    = ctrl_r.mem_write;
    assign IRload      = ctrl_r.ir_load;
    assign MDRload     = ctrl_r.mdr_load;
    assign R1R2Load    = ctrl_r.r1r2_load;
    assign ExtLoad     = ctrl_r.ext_load;
    assign ALU1        = ctrl_r.alu1;
    assign ALU2        = ctrl_r.alu2;
    assign ALUop       = ctrl_r.alu_op;
    assign ALUOutWrite = ctrl_r.alu_out_write;
    assign FlagWrite   = ctrl_r.flag_write;
    assign RegIn       = ctrl_r.reg_in;
    assign RFWrite     = ctrl_r.rf_write;
    assign Halt        = ctrl_r.halt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model queues
// the expected control word of every cycle; a monitor compares on each falling edge.
module tb_multicycle_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Instr = 4'b0000;
    logic       N = 1'b0;
    logic       Z = 1'b0;
    logic       PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, R1Sel;
    logic       R1R2Load, ExtLoad, ALU1, ALUOutWrite, FlagWrite, RegIn, RFWrite, Halt;
    logic [2:0] ALU2, ALUop;

    typedef struct packed {
        logic       pc_write;
        logic       addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       ir_load;
        logic       mdr_load;
        logic       r1_sel;
        logic       r1r2_load;
        logic       ext_load;
        logic       alu1;
        logic [2:0] alu2;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       flag_write;
        logic       reg_in;
        logic       rf_write;
        logic       halt;
    } ov_t;

    ov_t   act_v;
    ov_t   exp_q[$];
    string name_q[$];
    ov_t   seq_q[$];
    int    tests = 0;
    int    fails = 0;

    multicycle_ctrl dut (
        .clock(clock), .reset(reset), .Instr(Instr), .N(N), .Z(Z),
        .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRload(IRload), .MDRload(MDRload), .R1Sel(R1Sel), .R1R2Load(R1R2Load),
        .ExtLoad(ExtLoad), .ALU1(ALU1), .ALU2(ALU2), .ALUop(ALUop),
        .ALUOutWrite(ALUOutWrite), .FlagWrite(FlagWrite), .RegIn(RegIn),
        .RFWrite(RFWrite), .Halt(Halt)
    );

    assign act_v = {PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, R1Sel,
                    R1R2Load, ExtLoad, ALU1, ALU2, ALUop, ALUOutWrite, FlagWrite,
                    RegIn, RFWrite, Halt};

    always #5 clock = ~clock;

    // monitor: one expected control word per cycle, sampled mid-cycle
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            ov_t   e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            if (act_v !== e) begin
                fails++;
                $display("FAIL %s: got %h expected %h", nm, act_v, e);
            end
        end
    end

    function automatic ov_t v_halt();
        ov_t v = '0;
        v.halt = 1'b1;
        return v;
    endfunction

    // reference model: per-cycle control words for one instruction, from the opcode rules
    function automatic void build(input logic [3:0] op, input logic n, input logic z);
        ov_t v;
        seq_q.delete();
        v = '0;
        v.pc_write = 1'b1; v.addr_sel = 1'b1; v.mem_read = 1'b1; v.ir_load = 1'b1;
        v.alu2 = 3'b001;
        seq_q.push_back(v);
        v = '0;
        v.r1r2_load = 1'b1; v.ext_load = 1'b1; v.r1_sel = (op[2:0] == 3'b111);
        seq_q.push_back(v);
        if (op == 4'b0000) begin
            v = '0; v.mem_read = 1'b1; v.mdr_load = 1'b1;
            seq_q.push_back(v);
            v = '0; v.rf_write = 1'b1;
            seq_q.push_back(v);
        end else if (op == 4'b0010) begin
            v = '0; v.mem_write = 1'b1;
            seq_q.push_back(v);
        end else if (op == 4'b0100 || op == 4'b0110 || op == 4'b1000 || op[1:0] == 2'b11) begin
            v = '0; v.alu1 = 1'b1; v.alu_out_write = 1'b1; v.flag_write = 1'b1;
            if (op == 4'b0110)            v.alu_op = 3'b001;
            else if (op == 4'b1000)       v.alu_op = 3'b011;
            else if (op[2:0] == 3'b111) begin v.alu2 = 3'b011; v.alu_op = 3'b010; end
            else if (op[2:0] == 3'b011) begin v.alu2 = 3'b100; v.alu_op = 3'b100; end
            seq_q.push_back(v);
            v = '0; v.reg_in = 1'b1; v.rf_write = 1'b1;
            seq_q.push_back(v);
        end else if (op == 4'b0101 || op == 4'b1001 || op == 4'b1101) begin
            v = '0; v.alu2 = 3'b010;
            v.pc_write = (op == 4'b0101) ? z : ((op == 4'b1001) ? !z : !n);
            seq_q.push_back(v);
        end else if (op == 4'b0001) begin
            seq_q.push_back(v_halt());
        end
    endfunction

    // drive one instruction (at most limit cycles); IR holds junk during FETCH
    task automatic run(input logic [3:0] op, input logic n, input logic z, input int limit);
        build(op, n, z);
        for (int i = 0; i < seq_q.size() && i < limit; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) begin
                Instr = 4'($urandom_range(0, 15));
                N = n;
                Z = z;
            end else if (i == 1) begin
                Instr = op;
            end
            exp_q.push_back(seq_q[i]);
            name_q.push_back($sformatf("op%b_cyc%0d", op, i));
        end
    endtask

    task automatic idle(input ov_t v, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            exp_q.push_back(v);
            name_q.push_back(tag);
        end
    endtask

    initial begin
        logic [3:0] rop;
        idle('0, 3, "in_reset");
        @(posedge clock); #1 reset = 1'b1;
        exp_q.push_back('0); name_q.push_back("idle_after_reset");

        run(4'b1010, 1'b0, 1'b0, 99);
        run(4'b0100, 1'b0, 1'b0, 99);
        run(4'b1111, 1'b0, 1'b0, 99);
        run(4'b0101, 1'b0, 1'b1, 99);
        run(4'b0101, 1'b0, 1'b0, 99);
        run(4'b0000, 1'b0, 1'b0, 99);
        run(4'b0010, 1'b0, 1'b0, 99);
        run(4'b1001, 1'b0, 1'b0, 99);
        run(4'b1001, 1'b0, 1'b1, 99);
        run(4'b1101, 1'b1, 1'b0, 99);
        run(4'b1101, 1'b0, 1'b1, 99);
        run(4'b0110, 1'b0, 1'b0, 99);
        run(4'b1000, 1'b0, 1'b0, 99);
        run(4'b0011, 1'b0, 1'b0, 99);
        run(4'b0111, 1'b0, 1'b0, 99);
        run(4'b1100, 1'b0, 1'b0, 99);

        for (int k = 0; k < 80; k++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'b0001) rop = 4'b1010;
            run(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 99);
        end

        run(4'b0001, 1'b0, 1'b0, 99);
        idle(v_halt(), 20, "halt_hold");

        @(posedge clock); #1 reset = 1'b0;
        exp_q.push_back('0); name_q.push_back("reset_from_halt");
        idle('0, 1, "in_reset2");
        @(posedge clock); #1 reset = 1'b1;
        exp_q.push_back('0); name_q.push_back("idle_after_reset2");

        run(4'b0000, 1'b0, 1'b0, 3);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        tests++;
        if (act_v !== '0) begin
            fails++;
            $display("FAIL reset_mid_ld1: got %h expected %h", act_v, ov_t'('0));
        end
        idle('0, 1, "in_reset3");
        @(posedge clock); #1 reset = 1'b1;
        exp_q.push_back('0); name_q.push_back("idle_after_reset3");
        run(4'b1010, 1'b0, 1'b0, 99);
        run(4'b0100, 1'b0, 1'b0, 99);

        @(negedge clock);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the 8-bit processor datapath. It sequences each instruction through fetch, decode, execute and writeback states. It drives every datapath enable and mux select, including R1Sel and the loads for the immediate extenders (ZE3/ZE5/SE4) that are currently tied high. It sits beside the datapath in the processor top level and replaces all static tie-offs.

## Interface
Parameters:
- none; all encodings are constants in the shared package.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low (reset==0 clears state immediately)
- Instr  in  4  IR[3:0], opcode field, valid from DECODE onward
- N  in  1  negative flag register output
- Z  in  1  zero flag register output
- PCwrite  out  1  load PC from ALU result
- AddrSel  out  1  memory address: 1=PC, 0=R2
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRload  out  1  load IR from memory data
- MDRload  out  1  load MDR from memory data
- R1Sel  out  1  R1 read address: 1=K1 (reg 1, for ORI), 0=IR[7:6]
- R1R2Load  out  1  load R1/R2 operand registers
- ExtLoad  out  1  shared load for ZE3/ZE5/SE4 immediate registers
- ALU1  out  1  ALU A: 0=PC, 1=R1
- ALU2  out  3  ALU B: 000 R2, 001 const 1, 010 SE4, 011 ZE5, 100 ZE3
- ALUop  out  3  000 add, 001 sub, 010 or, 011 nand, 100 shift
- ALUOutWrite  out  1  load ALUOut register
- FlagWrite  out  1  update N/Z from ALU
- RegIn  out  1  RF write data: 1=ALUOut, 0=MDR
- RFWrite  out  1  register file write enable
- Halt  out  1  processor stopped

## Operation
- Opcode classes (Instr): 0000 LOAD, 0010 STORE, 0100 ADD, 0110 SUB, 1000 NAND, x111 ORI, x011 SHIFT, 0101 BZ, 1001 BNZ, 1101 BPZ, 0001 STOP, 1010 NOP. Every other code executes as NOP.
- States: RESET, FETCH, DECODE, LD1, LD2, ST, EXEC, WB, BR, HALT.
- RESET -> FETCH unconditionally. This gives one idle cycle after reset release.
- FETCH: AddrSel=1, MemRead=1, IRload=1, ALU1=0, ALU2=001, ALUop=add, PCwrite=1. Next state: DECODE.
- DECODE: R1R2Load=1, ExtLoad=1, R1Sel=(Instr[2:0]==111). Next state by class:
  - LOAD -> LD1
  - STORE -> ST
  - ADD/SUB/NAND/ORI/SHIFT -> EXEC
  - branch -> BR
  - STOP -> HALT
  - NOP -> FETCH
- LD1: AddrSel=0, MemRead=1, MDRload=1. Next state: LD2.
- LD2: RegIn=0, RFWrite=1. Next state: FETCH.
- ST: AddrSel=0, MemWrite=1. Next state: FETCH.
- EXEC: ALU1=1, ALUOutWrite=1, FlagWrite=1. Next state: WB. Per-class ALU setup:
  - ADD: ALU2=000, ALUop=add
  - SUB: ALU2=000, ALUop=sub
  - NAND: ALU2=000, ALUop=nand
  - ORI: ALU2=011, ALUop=or
  - SHIFT: ALU2=100, ALUop=shift
- WB: RegIn=1, RFWrite=1. Next state: FETCH.
- BR: ALU1=0, ALU2=010, ALUop=add. PCwrite=1 only when taken:
  - BZ: Z=1
  - BNZ: Z=0
  - BPZ: N=0
  - Next state: FETCH.
- HALT: Halt=1. Remains in HALT until reset.
- All strobes not listed for a state are 0. Select outputs are 0 unless listed.

## Timing
- Moore machine: outputs decode from the state register and the stable Instr. There is no extra output latency.
- Cycles per instruction:
  - LOAD 4, ALU-class 4
  - STORE 3, branch 3
  - NOP 2
  - STOP 2 to reach HALT
- Branch offset is relative to PC+1, because PC was incremented in FETCH.
- N/Z are sampled in BR and reflect the most recent EXEC only. LOAD, STORE and branches never write flags.
- Reset asserted in any state: state becomes RESET asynchronously, and all outputs go to 0 within the same cycle. This includes Halt, and it applies mid-instruction with no partial writeback.
- Reset values: every output is 0.

## Structure
- Shared package `cpu_pkg`:
  - state enum
  - opcode constants
  - ALU2 and ALUop encodings
  - AddrSel/RegIn meaning constants
- Sub-module `instr_class_decode`: combinational Instr[3:0] -> class one-hot, with priority for x111/x011 patterns. The FSM uses it in DECODE, EXEC and BR.

## Test plan
- Reset release, then NOP (1010): states RESET, FETCH, DECODE, FETCH. PCwrite pulses only in FETCH. Halt=0.
- ADD (0100): EXEC shows ALU1=1, ALU2=000, ALUop=000, FlagWrite=1. WB shows RFWrite=1, RegIn=1. 4 cycles total.
- ORI (1111): DECODE has R1Sel=1 and ExtLoad=1. EXEC has ALU2=011, ALUop=010.
- BZ (0101) with Z=1: BR has PCwrite=1, ALU2=010. Repeat with Z=0: PCwrite=0, return to FETCH.
- LOAD then STORE:
  - LOAD: LD1 has AddrSel=0, MemRead=1, MDRload=1. LD2 has RFWrite=1, RegIn=0.
  - STORE: ST has MemWrite=1, with no RFWrite.
- STOP (0001): Halt=1 held for 20 cycles. Then assert reset=0 mid-LD1 of a later LOAD: all outputs 0 immediately, and FETCH restarts after release.
